// File: rtl/dbgu32_pkg.sv
// Shared constants, state encoding and a byte-select helper for the debug-unit
// command parser.
package dbgu32_pkg;

  localparam logic [7:0] OP_SETADR = 8'h01;
  localparam logic [7:0] OP_HALT   = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h04;
  localparam logic [7:0] OP_READ   = 8'h05;

  typedef logic [2:0] dbgu_state_t;

  localparam dbgu_state_t StIdle   = 3'd0;
  localparam dbgu_state_t StArgAdr = 3'd1;
  localparam dbgu_state_t StArgDat = 3'd2;
  localparam dbgu_state_t StMemWr  = 3'd3;
  localparam dbgu_state_t StMemRd  = 3'd4;
  localparam dbgu_state_t StTx     = 3'd5;

  // Little-endian byte lane of a word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dbgu32_timeout.sv
// Inter-byte timeout: reloads on kick, counts down while enabled, and flags
// expiry once the count has run out.
module dbgu32_timeout #(
  parameter int unsigned TIMEOUT_CYC = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= W'(TIMEOUT_CYC);
    end else if (kick) begin
      cnt_q <= W'(TIMEOUT_CYC);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/dbgu32_cmd.sv
// Debug UART command parser: assembles little-endian frames, drives single-word
// memory accesses, streams read data back and controls CPU reset.
module dbgu32_cmd
  import dbgu32_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned TIMEOUT_CYC = CLK_HZ / 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  input  logic [31:0] dbg_di,
  input  logic        dbg_mem_ready,
  output logic        cpu_n_reset,
  output logic        rx_overrun
);

  dbgu_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] shifted;

  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        mem_op_q, mem_op_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] do_q, do_d;
  logic [3:0]  wren_q, wren_d;
  logic        cpu_n_reset_q, cpu_n_reset_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic kick;
  logic to_en;
  logic expired;

  assign shifted = {rx_data, shift_q[31:8]};
  assign to_en   = (state_q == StArgAdr) || (state_q == StArgDat);

  dbgu32_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .kick   (kick),
    .en     (to_en),
    .expired(expired)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rdata_d       = rdata_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    mem_op_d      = mem_op_q;
    adr_d         = adr_q;
    do_d          = do_q;
    wren_d        = wren_q;
    cpu_n_reset_d = cpu_n_reset_q;
    rx_overrun_d  = 1'b0;
    kick          = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          kick = 1'b1;
          case (rx_data)
            OP_SETADR: begin
              state_d = StArgAdr;
              cnt_d   = 2'd0;
              shift_d = '0;
            end
            OP_WRITE: begin
              state_d = StArgDat;
              cnt_d   = 2'd0;
              shift_d = '0;
            end
            OP_READ: begin
              state_d  = StMemRd;
              mem_op_d = 1'b1;
              wren_d   = 4'h0;
            end
            OP_HALT: cpu_n_reset_d = 1'b0;
            OP_RUN:  cpu_n_reset_d = 1'b1;
            default: ;
          endcase
        end
      end

      StArgAdr, StArgDat: begin
        // A byte arriving together with expiry is still taken.
        if (rx_valid) begin
          kick    = 1'b1;
          shift_d = shifted;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == StArgAdr) begin
              adr_d   = shifted;
              state_d = StIdle;
            end else begin
              do_d     = shifted;
              mem_op_d = 1'b1;
              wren_d   = 4'hF;
              state_d  = StMemWr;
            end
          end
        end else if (expired) begin
          state_d = StIdle;
          shift_d = '0;
        end
      end

      StMemWr: begin
        rx_overrun_d = rx_valid;
        if (dbg_mem_ready) begin
          mem_op_d = 1'b0;
          wren_d   = 4'h0;
          adr_d    = adr_q + 32'd4;
          state_d  = StIdle;
        end
      end

      StMemRd: begin
        rx_overrun_d = rx_valid;
        if (dbg_mem_ready) begin
          mem_op_d   = 1'b0;
          adr_d      = adr_q + 32'd4;
          rdata_d    = dbg_di;
          tx_valid_d = 1'b1;
          tx_data_d  = dbg_di[7:0];
          cnt_d      = 2'd0;
          state_d    = StTx;
        end
      end

      StTx: begin
        rx_overrun_d = rx_valid;
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            tx_data_d = get_byte(rdata_q, cnt_q + 2'd1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      shift_q       <= '0;
      rdata_q       <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      mem_op_q      <= 1'b0;
      adr_q         <= '0;
      do_q          <= '0;
      wren_q        <= 4'h0;
      cpu_n_reset_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rdata_q       <= rdata_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      mem_op_q      <= mem_op_d;
      adr_q         <= adr_d;
      do_q          <= do_d;
      wren_q        <= wren_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign dbg_wren    = wren_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_dbgu32_cmd.sv
// Bench for dbgu32_cmd: command-level model plus memory responder, compared
// against the DUT outputs on every falling edge.
module tb_dbgu32_cmd;

  localparam int unsigned ClkHz = 3000;
  localparam int unsigned To    = ClkHz / 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_di = '0;
  logic        dbg_mem_ready = 1'b0;
  logic        cpu_n_reset;
  logic        rx_overrun;

  dbgu32_cmd #(
    .CLK_HZ(ClkHz)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .dbg_mem_op   (dbg_mem_op),
    .dbg_adr      (dbg_adr),
    .dbg_do       (dbg_do),
    .dbg_wren     (dbg_wren),
    .dbg_di       (dbg_di),
    .dbg_mem_ready(dbg_mem_ready),
    .cpu_n_reset  (cpu_n_reset),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Command-level model of the unit.
  logic [31:0] m_adr = '0, m_do = '0;
  logic        m_run = 1'b0, m_memop = 1'b0, m_write = 1'b0, m_busy = 1'b0;
  logic [7:0]  pq[$];
  logic [7:0]  txq[$];
  int          last_acc = 0;
  int          ovr_cyc = -10;

  logic [31:0] mem[logic [31:0]];
  int          wr_cnt = 0;
  logic [31:0] wr_adr = '0, wr_dat = '0;
  logic [3:0]  wr_en = '0;
  logic [7:0]  txlog[$];
  int          ovr_seen = 0;
  int          resp_lat = 0;
  bit          stall = 1'b0;
  bit          hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_adr = '0; m_do = '0; m_run = 1'b0; m_memop = 1'b0; m_write = 1'b0; m_busy = 1'b0;
    pq.delete(); txq.delete(); ovr_cyc = -10;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (pq.size() != 0 && (cyc - last_acc) > int'(To) + 1) pq.delete();
    last_acc = cyc;
    if (pq.size() == 0) begin
      case (b)
        8'h01, 8'h04: pq.push_back(b);
        8'h05: begin m_memop = 1'b1; m_write = 1'b0; m_busy = 1'b1; end
        8'h02: m_run = 1'b0;
        8'h03: m_run = 1'b1;
        default: ;
      endcase
    end else begin
      pq.push_back(b);
      if (pq.size() == 5) begin
        w = {pq[4], pq[3], pq[2], pq[1]};
        if (pq[0] == 8'h01) m_adr = w;
        else begin
          m_do = w; m_memop = 1'b1; m_write = 1'b1; m_busy = 1'b1;
        end
        pq.delete();
      end
    end
  endfunction

  function automatic logic [31:0] txword();
    if (txlog.size() < 4) return 32'hxxxx_xxxx;
    return {txlog[3], txlog[2], txlog[1], txlog[0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit busy;
    busy = m_busy;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
    if (busy) ovr_cyc = cyc;
    else model_byte(b);
  endtask

  task automatic send4(input logic [7:0] op, input logic [31:0] w);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((m_busy || txq.size() != 0) && k < 500) begin tick(1); k++; end
    n_chk++;
    if (k >= 500) begin
      n_fail++;
      $display("FAIL %s: command still busy after %0d cycles, required idle", name, k);
    end
  endtask

  task automatic wait_txv(input string name);
    int k = 0;
    while (!tx_valid && k < 200) begin tick(1); k++; end
    n_chk++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL %s: tx_valid still 0 after %0d cycles, required 1", name, k);
    end
  endtask

  // Memory responder with programmable latency.
  initial forever begin
    @(posedge clk); #3;
    if (dbg_mem_op && !reset) begin
      repeat (resp_lat) begin @(posedge clk); #3; end
      dbg_di = mem.exists(dbg_adr) ? mem[dbg_adr] : (32'h5A5A_0000 ^ dbg_adr);
      dbg_mem_ready = 1'b1;
      if (dbg_wren == 4'hF) begin
        mem[dbg_adr] = dbg_do;
        wr_cnt++; wr_adr = dbg_adr; wr_dat = dbg_do; wr_en = dbg_wren;
      end
      @(posedge clk); #3;
      dbg_mem_ready = 1'b0;
      m_memop = 1'b0;
      m_adr   = m_adr + 32'd4;
      if (m_write) m_busy = 1'b0;
      else for (int i = 0; i < 4; i++) txq.push_back(dbg_di[8*i +: 8]);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    tx_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cpu_n_reset", 32'(cpu_n_reset), 32'(m_run));
    chk("dbg_adr", dbg_adr, m_adr);
    chk("dbg_do", dbg_do, m_do);
    chk("dbg_mem_op", 32'(dbg_mem_op), 32'(m_memop));
    chk("dbg_wren", 32'(dbg_wren), (m_memop && m_write) ? 32'hF : 32'h0);
    chk("rx_overrun", 32'(rx_overrun), 32'(cyc == ovr_cyc));
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (tx_valid && txq.size() != 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    if (rx_overrun) ovr_seen++;
    hs = tx_valid && tx_ready && (txq.size() != 0);
    if (hs) begin
      @(posedge clk); #1;
      if (txq.size() != 0) begin
        txlog.push_back(txq.pop_front());
        if (txq.size() == 0) m_busy = 1'b0;
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_adr", dbg_adr, 32'h0);
    chk("rst_cpu", 32'(cpu_n_reset), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_memop", 32'(dbg_mem_op), 32'h0);
    reset = 1'b0;
    tick(2);

    // Run / halt
    chk("run_pre", 32'(cpu_n_reset), 32'h0);
    send_byte(8'h03);
    chk("run", 32'(cpu_n_reset), 32'h1);
    tick(2);
    send_byte(8'h02);
    chk("halt", 32'(cpu_n_reset), 32'h0);
    send_byte(8'h03);

    // Write with late completion
    resp_lat = 3;
    send4(8'h01, 32'h0000_0020);
    chk("setadr", dbg_adr, 32'h20);
    send4(8'h04, 32'hAABB_CCDD);
    wait_done("write");
    chk("wr_cnt", 32'(wr_cnt), 32'd1);
    chk("wr_adr", wr_adr, 32'h20);
    chk("wr_dat", wr_dat, 32'hAABB_CCDD);
    chk("wr_en", 32'(wr_en), 32'hF);
    chk("wr_inc", dbg_adr, 32'h24);

    // Read with random tx stalls
    resp_lat = 1;
    txlog.delete();
    send4(8'h01, 32'h0000_0020);
    send_byte(8'h05);
    wait_done("read");
    chk("rd_len", 32'(txlog.size()), 32'd4);
    chk("rd_bytes", txword(), 32'hAABB_CCDD);
    chk("rd_inc", dbg_adr, 32'h24);

    // Address wrap
    resp_lat = 0;
    send4(8'h01, 32'hFFFF_FFFC);
    send4(8'h04, 32'h4433_2211);
    wait_done("wrap");
    chk("wrap_adr", wr_adr, 32'hFFFF_FFFC);
    chk("wrap_dat", wr_dat, 32'h4433_2211);
    chk("wrap_inc", dbg_adr, 32'h0);

    // Timeout resync, then a slow but in-time frame
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    tick(int'(To) + 10);
    send4(8'h01, 32'h0000_0020);
    chk("to_resync", dbg_adr, 32'h20);
    send_byte(8'h01); send_byte(8'h78);
    tick(int'(To) - 10);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("to_slow", dbg_adr, 32'h1234_5678);

    // Overrun during a stalled TX
    txlog.delete();
    ovr_seen = 0;
    stall = 1'b1;
    resp_lat = 2;
    send_byte(8'h05);
    wait_txv("ovr_txv");
    send_byte(8'hEE);
    tick(2);
    chk("ovr_cnt", 32'(ovr_seen), 32'd1);
    stall = 1'b0;
    wait_done("ovr_read");
    chk("ovr_bytes", txword(), 32'h486E_5678);
    chk("ovr_inc", dbg_adr, 32'h1234_567C);

    // Unknown opcode
    send_byte(8'h7E);
    tick(3);
    chk("bad_adr", dbg_adr, 32'h1234_567C);
    chk("bad_cpu", 32'(cpu_n_reset), 32'h1);
    chk("bad_memop", 32'(dbg_mem_op), 32'h0);
    chk("bad_txv", 32'(tx_valid), 32'h0);

    // Reset in the middle of TX
    stall = 1'b1;
    send_byte(8'h05);
    wait_txv("rst_mid_txv");
    @(negedge clk); #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mrst_txv", 32'(tx_valid), 32'h0);
    chk("mrst_txd", 32'(tx_data), 32'h0);
    chk("mrst_memop", 32'(dbg_mem_op), 32'h0);
    chk("mrst_adr", dbg_adr, 32'h0);
    chk("mrst_do", dbg_do, 32'h0);
    chk("mrst_wren", 32'(dbg_wren), 32'h0);
    chk("mrst_cpu", 32'(cpu_n_reset), 32'h0);
    chk("mrst_ovr", 32'(rx_overrun), 32'h0);
    tick(2);
    reset = 1'b0;
    stall = 1'b0;
    tick(2);

    // Clean read after reset
    txlog.delete();
    send4(8'h01, 32'h0000_0020);
    send_byte(8'h05);
    wait_done("post_rst_read");
    chk("post_rst_bytes", txword(), 32'hAABB_CCDD);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbgu32_cmd.md
# dbgu32_cmd

Command parser for the 32-bit debug unit. It sits between the debug UART byte receiver/transmitter and the SoC debug memory port (`dbg_adr`/`dbg_do`/`dbg_wren`/`dbg_mem_op`). It assembles little-endian command frames from received bytes, issues single-word memory writes and reads, streams read data back as bytes, and controls CPU reset. The CPU clock is never gated.

## Interface
- `CLK_HZ`, 12000000: system clock frequency; used only to derive `TIMEOUT_CYC`.
- `TIMEOUT_CYC`, CLK_HZ/100: inter-byte timeout in cycles (10 ms).
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  reset, asynchronous and active-high.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `tx_valid`  out  1  byte available for the UART transmitter.
- `tx_data`  out  8  byte to transmit.
- `tx_ready`  in  1  transmitter accepts `tx_data` in a cycle where `tx_valid && tx_ready`.
- `dbg_mem_op`  out  1  memory request; held high until `dbg_mem_ready`.
- `dbg_adr`  out  32  word address pointer.
- `dbg_do`  out  32  write data.
- `dbg_wren`  out  4  byte enables: 4'hF for a write, 4'h0 for a read.
- `dbg_di`  in  32  read data; valid in the cycle `dbg_mem_ready` is high.
- `dbg_mem_ready`  in  1  one-cycle completion strobe.
- `cpu_n_reset`  out  1  CPU reset, active low.
- `rx_overrun`  out  1  one-cycle pulse when a byte is dropped.

## Operation
- Opcodes:
  - 0x01 SETADR: 4 argument bytes, least significant first, loaded into `dbg_adr`.
  - 0x02 HALT: `cpu_n_reset` goes to 0.
  - 0x03 RUN: `cpu_n_reset` goes to 1.
  - 0x04 WRITE: 4 data bytes, least significant first, then a memory write.
  - 0x05 READ: a memory read, then 4 bytes transmitted, least significant first.
  - Any other opcode is ignored; the FSM stays in IDLE.
- FSM states: IDLE, ARG_ADR, ARG_DAT, MEM_WR, MEM_RD, TX.
- Byte counter: 2 bits, cleared on entry to ARG_ADR, ARG_DAT and TX.
- IDLE:
  - 0x01 -> ARG_ADR.
  - 0x04 -> ARG_DAT.
  - 0x05 -> MEM_RD.
  - 0x02 and 0x03 act in the same cycle the opcode is received; the FSM stays in IDLE.
- ARG_ADR / ARG_DAT:
  - Each byte shifts into bits [31:24] of a 32-bit shift register; the previous contents shift right by 8.
  - After the 4th byte, ARG_ADR loads `dbg_adr` and returns to IDLE.
  - After the 4th byte, ARG_DAT loads `dbg_do` and goes to MEM_WR.
- MEM_WR: `dbg_mem_op`=1, `dbg_wren`=4'hF until `dbg_mem_ready`, then IDLE.
- MEM_RD: `dbg_mem_op`=1, `dbg_wren`=0 until `dbg_mem_ready`; capture `dbg_di`, then TX.
- Auto-increment: after every completed 0x04 or 0x05 access, `dbg_adr` += 4, wrapping modulo 2^32.
- TX: present byte `cnt` of the captured word; advance on each handshake; after the 4th handshake -> IDLE.
- A byte received in MEM_WR, MEM_RD or TX is discarded and pulses `rx_overrun`. State is unaffected.
- Timeout: the counter resets on every accepted byte. Reaching `TIMEOUT_CYC` in ARG_ADR or ARG_DAT sends the FSM to IDLE and discards the partial shift register. `dbg_adr` and `dbg_do` keep their old values.
- MEM and TX states have no timeout; they wait indefinitely.
- Asynchronous reset mid-operation aborts the current command. Any partially transferred TX word is lost.

## Timing
- Reset values:
  - FSM in IDLE.
  - `tx_valid`=0, `tx_data`=0.
  - `dbg_mem_op`=0, `dbg_adr`=0, `dbg_do`=0, `dbg_wren`=0.
  - `cpu_n_reset`=0: the CPU is held in reset until RUN.
  - `rx_overrun`=0.
- All outputs are registered.
- `dbg_mem_op` rises on the clock edge after the last argument byte (write) or after the opcode (read).
- `dbg_mem_op` falls on the edge after `dbg_mem_ready`.
- `dbg_mem_ready` may arrive in the first cycle `dbg_mem_op` is high.
- `tx_valid` rises one cycle after `dbg_mem_ready`. `tx_data` is stable while `tx_valid && !tx_ready`.
- Back-to-back TX bytes are possible: the next byte is valid in the cycle after a handshake.
- `cpu_n_reset` changes one cycle after the 0x02/0x03 strobe.
- `rx_valid` coincident with a timeout expiry: the byte wins, and the counter resets.

## Structure
- Shared package `dbgu32_pkg`:
  - opcode constants `OP_SETADR`, `OP_HALT`, `OP_RUN`, `OP_WRITE`, `OP_READ`;
  - state enum `dbgu_state_t`.
- One sub-module is natural: `dbgu32_timeout`, a loadable down-counter with `kick`/`expired` ports.
- Everything else lives in `dbgu32_cmd`.

## Test plan
- Program and release: after reset, RUN (03) -> `cpu_n_reset`=1 one cycle later; HALT (02) -> `cpu_n_reset`=0.
- Write: 01 20 00 00 00, then 04 DD CC BB AA, with `dbg_mem_ready` 3 cycles late.
  - One write to `dbg_adr`=0x00000020, `dbg_do`=0xAABBCCDD, `dbg_wren`=F.
  - Afterwards `dbg_adr`=0x24.
- Read: 01 20 00 00 00, 05, with `dbg_di`=0xAABBCCDD.
  - TX bytes DD CC BB AA in order, with `tx_ready` randomly stalled.
  - Afterwards `dbg_adr`=0x24.
- Wrap: SETADR FC FF FF FF, then a write -> access at 0xFFFFFFFC, after which `dbg_adr`=0x00000000.
- Timeout resync: 01 12 34, then idle past `TIMEOUT_CYC`, then 01 20 00 00 00.
  - `dbg_adr`=0x20.
  - 0x12 and 0x34 are not shifted in.
- Overrun and bad opcode:
  - A byte sent during TX -> `rx_overrun` pulse, TX bytes unchanged.
  - Opcode 0x7E -> no outputs change.
  - Reset asserted mid-TX -> all outputs return to reset values immediately.
